datapath_unpack_fifo: RTL and testbench

- Reverse-direction companion to the 128→192 packing datapath FIFO.
- Buffers 192-bit words written by the slow 192-bit side (e.g. one per CLK_DIV strobe).
- Each word is emitted as two 128-bit beats on a valid/ready stream toward the 128-bit host interface, the exact inverse of the 2×128→192 packing.
- Sits between the 192-bit result path and the 128-bit DMA/driver stream.

---
 rtl/datapath_unpack_fifo.sv | 145 ++++++++++++++
 tb/tb_datapath_unpack_fifo.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_unpack_fifo.sv
// Unpacking FIFO: stores 192-bit words and emits each one as two 128-bit beats
// (low 128 bits first, then the zero-extended upper 64 bits) on a valid/ready stream.
module datapath_unpack_fifo #(
  parameter int INPUT_DATA_WIDTH  = 192,
  parameter int OUTPUT_DATA_WIDTH = 128,
  parameter int DEPTH             = 1024,
  parameter int DEPTH_SIZE        = 10
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         wr,
  input  logic [INPUT_DATA_WIDTH-1:0]  data_in,
  input  logic                         ovf_clr,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [OUTPUT_DATA_WIDTH-1:0] out_data,
  output logic                         out_last,
  output logic                         full,
  output logic                         empty,
  output logic                         threshold,
  output logic [DEPTH_SIZE:0]          data_count,
  output logic                         overflow
);

  localparam int                  UPPER_W  = INPUT_DATA_WIDTH - OUTPUT_DATA_WIDTH;
  localparam logic [DEPTH_SIZE:0] PTR_ONE  = (DEPTH_SIZE+1)'(1);
  localparam logic [DEPTH_SIZE:0] HALF_CNT = (DEPTH_SIZE+1)'(DEPTH / 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2
  } state_t;

  state_t                      r_state;
  logic [DEPTH_SIZE:0]         r_wptr;
  logic [DEPTH_SIZE:0]         r_rptr;
  logic [INPUT_DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [INPUT_DATA_WIDTH-1:0] r_hold;
  logic                        r_out_valid;
  logic                        r_out_last;
  logic                        r_overflow;

  logic w_wr_en;
  logic w_load;
  logic w_pop;

  assign full       = (r_wptr[DEPTH_SIZE] != r_rptr[DEPTH_SIZE]) &&
                      (r_wptr[DEPTH_SIZE-1:0] == r_rptr[DEPTH_SIZE-1:0]);
  assign empty      = (r_wptr == r_rptr);
  assign data_count = r_wptr - r_rptr;
  assign threshold  = (data_count >= HALF_CNT);

  // full is taken from the registered pointers, so a pop in the same cycle cannot make room.
  assign w_wr_en = wr & ~full;
  assign w_load  = (r_state == S_IDLE) || ((r_state == S_HI) && out_ready);
  assign w_pop   = w_load & ~empty;

  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign overflow  = r_overflow;

  // Storage and its read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wptr[DEPTH_SIZE-1:0]] <= data_in;
    end
    if (w_pop) begin
      r_hold <= r_mem[r_rptr[DEPTH_SIZE-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (ovf_clr) begin
        r_overflow <= 1'b0;
      end else if (wr && full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_rptr      <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      case (r_state)
        S_IDLE: begin
          if (!empty) begin
            r_state     <= S_LO;
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b0;
          end
        end
        S_LO: begin
          if (out_ready) begin
            r_state    <= S_HI;
            r_out_last <= 1'b1;
          end
        end
        S_HI: begin
          if (out_ready) begin
            if (!empty) begin
              r_state    <= S_LO;
              r_out_last <= 1'b0;
            end else begin
              r_state     <= S_IDLE;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
        end
      endcase
    end
  end

  // Beat selection from the held word; forced to zero outside LO/HI so reset clears it at once.
  always_comb begin
    out_data = '0;
    case (r_state)
      S_LO:    out_data = r_hold[OUTPUT_DATA_WIDTH-1:0];
      S_HI:    out_data = {{(OUTPUT_DATA_WIDTH-UPPER_W){1'b0}},
                           r_hold[INPUT_DATA_WIDTH-1:OUTPUT_DATA_WIDTH]};
      default: out_data = '0;
    endcase
  end

endmodule

// File: tb/tb_datapath_unpack_fifo.sv
// Directed bench for datapath_unpack_fifo at DEPTH=4: a beat scoreboard is filled on each
// accepted write and drained on every output handshake.
module tb_datapath_unpack_fifo;

  localparam int DS = 2;

  logic         clk;
  logic         rstn;
  logic         wr;
  logic [191:0] data_in;
  logic         ovf_clr;
  logic         out_ready;
  logic         out_valid;
  logic [127:0] out_data;
  logic         out_last;
  logic         full;
  logic         empty;
  logic         threshold;
  logic [DS:0]  data_count;
  logic         overflow;

  datapath_unpack_fifo #(
    .INPUT_DATA_WIDTH (192),
    .OUTPUT_DATA_WIDTH(128),
    .DEPTH            (4),
    .DEPTH_SIZE       (DS)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .wr        (wr),
    .data_in   (data_in),
    .ovf_clr   (ovf_clr),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .full      (full),
    .empty     (empty),
    .threshold (threshold),
    .data_count(data_count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           vectors;
  int           miscompares;
  int           beats;
  int           gaps;
  bit           stream_on;
  logic [128:0] sb[$];

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [191:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Checks the beat about to be accepted at the coming edge, then advances one cycle.
  task automatic tick();
    logic [128:0] exp;
    if (out_valid === 1'b1 && out_ready) begin
      vectors++;
      assert (sb.size() != 0) else begin
        miscompares++;
        $error("FAIL beat_unexpected observed=%h expected=none", {out_last, out_data});
      end
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        check("beat", {out_last, out_data}, exp);
      end
      beats++;
    end else if (stream_on && beats > 0 && sb.size() > 0 && out_valid !== 1'b1) begin
      gaps++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [191:0] w, input bit accept);
    wr      = 1'b1;
    data_in = w;
    if (accept) begin
      sb.push_back({1'b0, w[127:0]});
      sb.push_back({1'b1, 64'h0, w[191:128]});
    end
    tick();
    wr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [191:0] w;
    int           exp_cnt[5];
    vectors     = 0;
    miscompares = 0;
    beats       = 0;
    gaps        = 0;
    stream_on   = 1'b0;
    exp_cnt     = '{1, 1, 2, 3, 4};
    rstn        = 1'b1;
    wr          = 1'b0;
    data_in     = '0;
    ovf_clr     = 1'b0;
    out_ready   = 1'b0;

    // Reset state
    #3 rstn = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", data_count, 0);
    check("rst_threshold", threshold, 0);
    check("rst_overflow", overflow, 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    tick();

    // Single word, latency and bit ordering
    out_ready = 1'b1;
    write_word({64'hCCCC_0003, 64'hBBBB_0002, 64'hAAAA_0001}, 1'b1);
    check("lat_valid_n1", out_valid, 0);
    check("lat_empty_n1", empty, 0);
    tick();
    check("lat_valid_n2", out_valid, 1);
    check("beat0_data", out_data, {64'hBBBB_0002, 64'hAAAA_0001});
    check("beat0_last", out_last, 0);
    tick();
    check("beat1_data", out_data, {64'h0, 64'hCCCC_0003});
    check("beat1_last", out_last, 1);
    tick();
    check("single_done_valid", out_valid, 0);
    check("single_done_empty", empty, 1);
    check("single_done_last", out_last, 0);
    check("single_sb_empty", sb.size(), 0);

    // Fill to full with the output stalled
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      write_word(rand_word(), 1'b1);
      check("fill_count", data_count, exp_cnt[i]);
      check("fill_threshold", threshold, (exp_cnt[i] >= 2) ? 1 : 0);
    end
    check("fill_full", full, 1);
    write_word(rand_word(), 1'b0);
    check("ovf_full", full, 1);
    check("ovf_set", overflow, 1);
    check("ovf_count", data_count, 4);
    ovf_clr = 1'b1;
    wr      = 1'b1;
    data_in = rand_word();
    tick();
    ovf_clr = 1'b0;
    wr      = 1'b0;
    check("ovf_clr_wins", overflow, 0);
    write_word(rand_word(), 1'b0);
    check("ovf_set2", overflow, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr", overflow, 0);

    // Backpressure in LO then HI
    beats = 0;
    for (int i = 0; i < 7; i++) begin
      check("bp_lo_valid", out_valid, 1);
      check("bp_lo_data", out_data, sb[0][127:0]);
      check("bp_lo_last", out_last, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_hi_valid", out_valid, 1);
      check("bp_hi_data", out_data, sb[0][127:0]);
      check("bp_hi_last", out_last, 1);
      tick();
    end

    // Write while full coinciding with a pop
    check("simul_pre_full", full, 1);
    out_ready = 1'b1;
    wr        = 1'b1;
    data_in   = rand_word();
    tick();
    wr        = 1'b0;
    out_ready = 1'b0;
    check("bp_handshakes", beats, 2);
    check("simul_overflow", overflow, 1);
    check("simul_count", data_count, 3);
    check("simul_full", full, 0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;

    // Drain the stored words in order
    out_ready = 1'b1;
    for (int i = 0; i < 40 && sb.size() > 0; i++) tick();
    check("drain_sb_empty", sb.size(), 0);
    check("drain_valid", out_valid, 0);
    check("drain_empty", empty, 1);

    // Streaming: 8 words at the output rate, wrapping the pointers twice
    beats     = 0;
    gaps      = 0;
    stream_on = 1'b1;
    for (int i = 0; i < 8; i++) begin
      write_word(rand_word(), 1'b1);
      tick();
    end
    for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
    stream_on = 1'b0;
    check("stream_beats", beats, 16);
    check("stream_gaps", gaps, 0);
    check("stream_sb_empty", sb.size(), 0);
    check("stream_overflow", overflow, 0);

    // Asynchronous reset in the middle of LO with three words queued
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) write_word(rand_word(), 1'b1);
    check("prerst_valid", out_valid, 1);
    check("prerst_count", data_count, 3);
    #2 rstn = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_last", out_last, 0);
    check("midrst_data", out_data, 0);
    check("midrst_empty", empty, 1);
    check("midrst_count", data_count, 0);
    sb.delete();
    @(posedge clk);
    #1 rstn = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("postrst_valid", out_valid, 0);
      tick();
    end
    check("postrst_empty", empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
